// File: rtl/pila_retorno.sv
// ---------------------------------------------------------------------------------------------
// pila_retorno -- return-address stack for the subroutine call/return path.
//
// A call pushes the return PC and a return pops it. The top entry is presented combinationally
// so the PC mux can consume it in the same cycle as the return instruction. Overflow either
// drops the push (OVF_WRAP=0) or overwrites the oldest entry (OVF_WRAP=1). Sticky ovf/udf
// flags feed err, which halts the processor.
//
// Parameters:
//   WIDTH    return-address width (PC width)
//   DEPTH    number of entries; power of two, at least 2
//   OVF_WRAP 0: push on full is dropped; 1: push on full overwrites the oldest entry
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous reset, active low
//   push     in   push din this cycle
//   pop      in   pop the top entry this cycle
//   din      in   return address to push
//   dout     out  top entry, 0 when empty
//   empty    out  count == 0
//   full     out  count == DEPTH
//   count    out  number of valid entries
//   ovf      out  sticky overflow flag
//   udf      out  sticky underflow flag
//   clr_err  in   synchronous clear of ovf/udf (a same-cycle error event wins)
//   err      out  ovf | udf
// ---------------------------------------------------------------------------------------------
module pila_retorno #(
   parameter int unsigned WIDTH    = 10,
   parameter int unsigned DEPTH    = 8,
   parameter bit          OVF_WRAP = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf,
   output logic                     udf,
   input  logic                     clr_err,
   output logic                     err
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ZERO = '0;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [PW-1:0] SP_ONE   = PW'(1);

   // Elaboration-time guard on the geometry: the pointer relies on natural modulo-DEPTH wrap.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pila_retorno: DEPTH must be a power of two and at least 2");
   end

   // Request decode
   typedef enum logic [1:0] {
      OpIdle = 2'b00,
      OpPop  = 2'b01,
      OpPush = 2'b10,
      OpBoth = 2'b11
   } op_e;

   // State
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    sp_q, sp_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;

   // Next-state helpers
   op_e              op;
   logic [PW-1:0]    sp_inc;
   logic [PW-1:0]    sp_dec;
   logic             is_empty;
   logic             is_full;
   logic             wr_en;
   logic [PW-1:0]    wr_addr;
   logic             ovf_set;
   logic             udf_set;

   assign op       = op_e'({push, pop});
   assign sp_inc   = sp_q + SP_ONE;
   assign sp_dec   = sp_q - SP_ONE;
   assign is_empty = (count_q == CNT_ZERO);
   assign is_full  = (count_q == CNT_FULL);

   // ------------------------------------------------------------------------------------------
   // Next-state decode; every decision is taken on the registered count.
   // ------------------------------------------------------------------------------------------
   always_comb begin
      sp_d    = sp_q;
      count_d = count_q;
      wr_en   = 1'b0;
      wr_addr = sp_q;
      ovf_set = 1'b0;
      udf_set = 1'b0;

      unique case (op)
         OpIdle: begin
         end

         OpPush: begin
            if (!is_full) begin
               wr_en   = 1'b1;
               wr_addr = sp_q;
               sp_d    = sp_inc;
               count_d = count_q + CNT_ONE;
            end else begin
               ovf_set = 1'b1;
               if (OVF_WRAP) begin
                  // Ring is full, so mem[sp] holds the oldest entry; overwrite it and keep count.
                  wr_en   = 1'b1;
                  wr_addr = sp_q;
                  sp_d    = sp_inc;
               end
            end
         end

         OpPop: begin
            if (!is_empty) begin
               sp_d    = sp_dec;
               count_d = count_q - CNT_ONE;
            end else begin
               udf_set = 1'b1;
            end
         end

         OpBoth: begin
            if (!is_empty) begin
               // Return immediately followed by a call: replace the top in place.
               wr_en   = 1'b1;
               wr_addr = sp_dec;
            end else begin
               // Nothing to pop: the push still happens, the pop is flagged.
               wr_en   = 1'b1;
               wr_addr = sp_q;
               sp_d    = sp_inc;
               count_d = CNT_ONE;
               udf_set = 1'b1;
            end
         end

         default: begin
         end
      endcase
   end

   // Sticky flags: a new event dominates a simultaneous clear.
   always_comb begin
      ovf_d = ovf_q;
      udf_d = udf_q;
      if (clr_err) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
      if (ovf_set) begin
         ovf_d = 1'b1;
      end
      if (udf_set) begin
         udf_d = 1'b1;
      end
   end

   // ------------------------------------------------------------------------------------------
   // Control state, asynchronously reset
   // ------------------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sp_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         sp_q    <= sp_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // Storage is not reset; dout masking keeps stale contents away from the PC mux.
   // Writes are suppressed while reset is held so requests seen in reset have no effect.
   always_ff @(posedge clk) begin
      if (wr_en && reset) begin
         mem[wr_addr] <= din;
      end
   end

   // ------------------------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------------------------
   assign dout  = is_empty ? '0 : mem[sp_dec];
   assign empty = is_empty;
   assign full  = is_full;
   assign count = count_q;
   assign ovf   = ovf_q;
   assign udf   = udf_q;
   assign err   = ovf_q | udf_q;

endmodule

// File: tb/tb_pila_retorno.sv
// ---------------------------------------------------------------------------------------------
// tb_pila_retorno -- directed bench for pila_retorno.
//
// Three instances share one stimulus stream: u_d8 (DEPTH=8, drop), u_d4 (DEPTH=4, drop) and
// u_w4 (DEPTH=4, wrap). Each scenario resets all of them and checks the relevant instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------------------------
module tb_pila_retorno;

   localparam int unsigned W = 10;

   logic          clk;
   logic          reset;
   logic          push;
   logic          pop;
   logic [W-1:0]  din;
   logic          clr_err;

   logic [W-1:0]  a_dout, b_dout, c_dout;
   logic          a_empty, b_empty, c_empty;
   logic          a_full, b_full, c_full;
   logic [3:0]    a_count;
   logic [2:0]    b_count, c_count;
   logic          a_ovf, b_ovf, c_ovf;
   logic          a_udf, b_udf, c_udf;
   logic          a_err, b_err, c_err;

   int unsigned   vectors;
   int unsigned   miscompares;

   pila_retorno #(.WIDTH(W), .DEPTH(8), .OVF_WRAP(1'b0)) u_d8 (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din), .dout(a_dout),
      .empty(a_empty), .full(a_full), .count(a_count), .ovf(a_ovf), .udf(a_udf),
      .clr_err(clr_err), .err(a_err)
   );

   pila_retorno #(.WIDTH(W), .DEPTH(4), .OVF_WRAP(1'b0)) u_d4 (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din), .dout(b_dout),
      .empty(b_empty), .full(b_full), .count(b_count), .ovf(b_ovf), .udf(b_udf),
      .clr_err(clr_err), .err(b_err)
   );

   pila_retorno #(.WIDTH(W), .DEPTH(4), .OVF_WRAP(1'b1)) u_w4 (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din), .dout(c_dout),
      .empty(c_empty), .full(c_full), .count(c_count), .ovf(c_ovf), .udf(c_udf),
      .clr_err(clr_err), .err(c_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      push    = 1'b0;
      pop     = 1'b0;
      clr_err = 1'b0;
   endtask

   // Assert reset between edges and confirm it acts without a clock.
   task automatic do_reset();
      reset = 1'b0;
      #1;
      check("rst_async_empty", {31'd0, a_empty}, 32'd1);
      cyc();
      reset = 1'b1;
      idle();
   endtask

   task automatic push_val(input logic [W-1:0] v);
      push = 1'b1;
      pop  = 1'b0;
      din  = v;
      cyc();
      push = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;

      // ---- Reset held with a push request pending -------------------------------------------
      reset   = 1'b0;
      push    = 1'b1;
      pop     = 1'b0;
      clr_err = 1'b0;
      din     = 10'h155;
      repeat (3) cyc();
      check("rst_empty", {31'd0, a_empty}, 32'd1);
      check("rst_count", {28'd0, a_count}, 32'd0);
      check("rst_dout",  {22'd0, a_dout},  32'd0);
      check("rst_err",   {31'd0, a_err},   32'd0);
      check("rst_full",  {31'd0, a_full},  32'd0);
      reset = 1'b1;
      cyc();
      push = 1'b0;
      check("post_rst_count", {28'd0, a_count}, 32'd1);
      check("post_rst_dout",  {22'd0, a_dout},  32'h155);

      // ---- LIFO order, DEPTH=8 --------------------------------------------------------------
      do_reset();
      push_val(10'h010);
      push_val(10'h020);
      push_val(10'h030);
      check("lifo_count3", {28'd0, a_count}, 32'd3);
      pop = 1'b1;
      check("lifo_pop1", {22'd0, a_dout}, 32'h030);
      cyc();
      check("lifo_pop2", {22'd0, a_dout}, 32'h020);
      cyc();
      check("lifo_pop3", {22'd0, a_dout}, 32'h010);
      cyc();
      pop = 1'b0;
      check("lifo_empty", {31'd0, a_empty}, 32'd1);
      check("lifo_dout0", {22'd0, a_dout},  32'd0);
      check("lifo_noerr", {31'd0, a_err},   32'd0);

      // ---- Overflow, drop (u_d4) ------------------------------------------------------------
      do_reset();
      for (int i = 1; i <= 4; i++) push_val(W'(i));
      check("drop_full4", {31'd0, b_full}, 32'd1);
      check("drop_noovf", {31'd0, b_ovf},  32'd0);
      push_val(10'd5);
      check("drop_ovf",   {31'd0, b_ovf},   32'd1);
      check("drop_err",   {31'd0, b_err},   32'd1);
      check("drop_count", {29'd0, b_count}, 32'd4);
      pop = 1'b1;
      for (int i = 4; i >= 1; i--) begin
         check("drop_pop", {22'd0, b_dout}, 32'(i));
         cyc();
      end
      pop = 1'b0;
      check("drop_empty", {31'd0, b_empty}, 32'd1);
      clr_err = 1'b1;
      cyc();
      clr_err = 1'b0;
      check("drop_clr_ovf", {31'd0, b_ovf}, 32'd0);

      // ---- Overflow, wrap (u_w4) ------------------------------------------------------------
      do_reset();
      for (int i = 1; i <= 6; i++) push_val(W'(i));
      check("wrap_count", {29'd0, c_count}, 32'd4);
      check("wrap_ovf",   {31'd0, c_ovf},   32'd1);
      check("wrap_full",  {31'd0, c_full},  32'd1);
      pop = 1'b1;
      for (int i = 6; i >= 3; i--) begin
         check("wrap_pop", {22'd0, c_dout}, 32'(i));
         cyc();
      end
      pop = 1'b0;
      check("wrap_empty", {31'd0, c_empty}, 32'd1);

      // ---- Simultaneous push+pop, underflow, flag clear (u_d8) ------------------------------
      do_reset();
      push_val(10'h0AA);
      push = 1'b1;
      pop  = 1'b1;
      din  = 10'h0BB;
      check("both_pre_dout", {22'd0, a_dout}, 32'h0AA);
      cyc();
      idle();
      check("both_count", {28'd0, a_count}, 32'd1);
      check("both_dout",  {22'd0, a_dout},  32'h0BB);
      check("both_noerr", {31'd0, a_err},   32'd0);
      pop = 1'b1;
      cyc();
      check("pop_to_empty", {31'd0, a_empty}, 32'd1);
      check("pop_no_udf",   {31'd0, a_udf},   32'd0);
      cyc();
      pop = 1'b0;
      check("udf_set",   {31'd0, a_udf},   32'd1);
      check("udf_count", {28'd0, a_count}, 32'd0);
      check("udf_err",   {31'd0, a_err},   32'd1);
      clr_err = 1'b1;
      cyc();
      clr_err = 1'b0;
      check("clr_udf", {31'd0, a_udf}, 32'd0);
      check("clr_err", {31'd0, a_err}, 32'd0);

      push = 1'b1;
      pop  = 1'b1;
      din  = 10'h123;
      cyc();
      idle();
      check("both_empty_count", {28'd0, a_count}, 32'd1);
      check("both_empty_udf",   {31'd0, a_udf},   32'd1);
      check("both_empty_dout",  {22'd0, a_dout},  32'h123);

      pop = 1'b1;
      cyc();
      check("drain_empty", {31'd0, a_empty}, 32'd1);
      clr_err = 1'b1;
      cyc();
      idle();
      check("clr_vs_udf", {31'd0, a_udf}, 32'd1);
      clr_err = 1'b1;
      cyc();
      clr_err = 1'b0;
      check("clr_final", {31'd0, a_udf}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
